// File: rtl/wt_pkg.sv
// Shared defaults, width helper and lane typedefs for the write-side width packer.
package wt_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int RATIO_DEF = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int LANE_W_DEF = clog2(RATIO_DEF);

    typedef logic [LANE_W_DEF-1:0] lane_idx_t;
    typedef logic [RATIO_DEF-1:0]  lane_mask_t;

endpackage

// File: rtl/wr_lane_acc.sv
// Lane accumulator: collects narrow beats into a wide word and flags completion.
// Lane order follows WR_PACK_MSB_FIRST_EN (MSB-first when defined, LSB-first otherwise).
module wr_lane_acc
    import wt_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int RATIO = RATIO_DEF
) (
    input  logic                    clk_wr,
    input  logic                    rstn,
    input  logic                    beat_en,
    input  logic [IN_W-1:0]         beat_data,
    input  logic                    beat_last,
    output logic                    complete,
    output logic [IN_W*RATIO-1:0]   word,
    output logic [RATIO-1:0]        word_mask
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = clog2(RATIO);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lane;
    logic [OUT_W-1:0] acc;
    logic [RATIO-1:0] acc_mask;

`ifdef WR_PACK_MSB_FIRST_EN
    assign lane = CNT_W'(RATIO - 1) - cnt;
`else
    assign lane = cnt;
`endif

    // Accumulated lanes merged with the beat presented this cycle.
    always_comb begin
        word                        = acc;
        word_mask                   = acc_mask;
        word[lane*IN_W +: IN_W]     = beat_data;
        word_mask[lane]             = 1'b1;
    end

    assign complete = beat_en && (beat_last || (cnt == CNT_W'(RATIO - 1)));

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values; the accumulator is plain flops, so it is reset with the rest.
    always_ff @(posedge clk_wr or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            acc      <= '0;
            acc_mask <= '0;
        end else if (complete) begin
            cnt      <= '0;
            acc      <= '0;
            acc_mask <= '0;
        end else if (beat_en) begin
            cnt      <= cnt + CNT_W'(1);
            acc      <= word;
            acc_mask <= word_mask;
        end
    end

endmodule

// File: rtl/wr_width_packer.sv
// Packs RATIO narrow beats into one FIFO word and drives the async FIFO write port.
// Optional build macro: WR_PACK_MSB_FIRST_EN selects MSB-first lane order.
module wr_width_packer
    import wt_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int RATIO = RATIO_DEF
) (
    input  logic                    clk_wr,
    input  logic                    rstn,
    input  logic                    in_valid,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    wr_req,
    output logic [IN_W*RATIO-1:0]   wr_data,
    output logic [RATIO-1:0]        wr_mask,
    input  logic                    full
);

    localparam int OUT_W = IN_W * RATIO;

    logic             beat_en;
    logic             out_fire;
    logic             complete;
    logic [OUT_W-1:0] word;
    logic [RATIO-1:0] word_mask;

    // Ready depends only on registered wr_req and the registered full flag.
    assign in_ready = !wr_req || !full;
    assign beat_en  = in_valid && in_ready;
    assign out_fire = wr_req && !full;

    wr_lane_acc #(
        .IN_W  (IN_W),
        .RATIO (RATIO)
    ) u_lane_acc (
        .clk_wr    (clk_wr),
        .rstn      (rstn),
        .beat_en   (beat_en),
        .beat_data (in_data),
        .beat_last (in_last),
        .complete  (complete),
        .word      (word),
        .word_mask (word_mask)
    );

    // A completion can only happen while the slot is empty or firing, so it may reload directly.
    always_ff @(posedge clk_wr or negedge rstn) begin
        if (!rstn) begin
            wr_req  <= 1'b0;
            wr_data <= '0;
            wr_mask <= '0;
        end else if (complete) begin
            wr_req  <= 1'b1;
            wr_data <= word;
            wr_mask <= word_mask;
        end else if (out_fire) begin
            wr_req  <= 1'b0;
        end
    end

endmodule

// File: doc/wr_width_packer.md
Name: wr_width_packer

Overview:
Write-domain producer that issues `wr_req` into the async FIFO write port (the gray-pointer/full logic on `clk_wr`). It accepts narrow `IN_W` beats over a valid/ready handshake and packs `RATIO` beats into one `OUT_W` FIFO word. It also flushes a partial word on `in_last`, holding requests stable while the FIFO reports `full`. It sits between the upstream narrow source and the FIFO write side.

Parameters:
- `IN_W`, 8, width of one input beat.
- `RATIO`, 4, beats per FIFO word; power of two, ≥2.
- `OUT_W`, `IN_W*RATIO`, FIFO data width; derived, not overridable.

Ports:
- `clk_wr` input 1: write-domain clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: input beat valid.
- `in_data` input `IN_W`: input beat.
- `in_last` input 1: final beat of burst; flush partial word.
- `in_ready` output 1: beat accepted when `in_valid && in_ready` at the rising edge.
- `wr_req` output 1: FIFO write request, registered.
- `wr_data` output `OUT_W`: packed word, registered.
- `wr_mask` output `RATIO`: lane-valid mask for `wr_data`, registered.
- `full` input 1: FIFO full, registered in the write domain.

Behaviour:
- Reset (async, `rstn`=0): lane counter 0, accumulator 0, `wr_req`=0, `wr_data`=0, `wr_mask`=0. `in_ready`=1 once reset releases.
- Reset mid-operation discards any partial accumulation and any pending output word without writing it.
- Internal state: lane counter `cnt` (`log2(RATIO)` bits), accumulator (`OUT_W` bits), accumulator mask (`RATIO` bits), output slot (`wr_req`/`wr_data`/`wr_mask`).
- Write fire: `out_fire = wr_req && !full` at the rising edge. Exactly one FIFO write per fire.
- `wr_req`, `wr_data` and `wr_mask` are held stable while `wr_req && full`.
- `in_ready = !wr_req || !full`. This is a registered-only path; there is no `in_valid` to `in_ready` dependency.
- On an accepted beat:
  - `in_data` goes to lane `cnt` (default lane order: lane 0 = bits `[IN_W-1:0]`).
  - Mask bit `cnt` is set.
- Completion occurs on an accepted beat with `cnt==RATIO-1` or `in_last=1`. On completion:
  - The output slot loads the accumulator contents plus the current beat.
  - `wr_req`=1 from the next cycle.
  - `cnt`, accumulator and mask are cleared.
- Latency: completing beat accepted at edge N → `wr_req`=1 in cycle N+1. With `full`=0, the write fires at edge N+1.
- Simultaneous fire and completion on the same edge: the slot reloads with the new word and `wr_req` stays 1. Full throughput is one beat per cycle, i.e. one FIFO write every `RATIO` cycles.
- Fire without completion: `wr_req`→0 next cycle.
- `in_last` at `cnt==0`: single-lane word, `wr_mask`=`0b0001`.
- `in_last` at `cnt==RATIO-1`: mask all ones, identical to a normal completion.
- Unfilled lanes of a partial word are driven 0.
- Counter wrap: `cnt` wraps `RATIO-1`→0 only via completion. There is no other wrap path.
- `full` asserted with no pending word has no effect on accumulation. Input stalls only while the slot is occupied and `full`=1.

Optional Feature:
- Macro: `WR_PACK_MSB_FIRST_EN`.
- Defined: the first beat of a word goes to the MSB lane (lane `RATIO-1-cnt`), and `wr_mask` bits are set MSB-down.
- Undefined: LSB-first packing as above.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package `wt_pkg`: `IN_W`/`RATIO` defaults, `clog2` function, lane-index typedef, mask typedef.
- One natural sub-module, `wr_lane_acc`: accumulator, counter and mask, with completion output. The top-level block keeps the output slot and the handshake.

Test Plan:
All scenarios use `IN_W`=8, `RATIO`=4.
1. Beats 0x11,0x22,0x33,0x44 back-to-back, `full`=0 → one-cycle `wr_req` the cycle after beat 4, `wr_data`=0x44332211, `wr_mask`=0xF.
2. Beats 0xAA,0xBB with `in_last` on 0xBB → `wr_data`=0x0000BBAA, `wr_mask`=0x3; next word restarts at lane 0.
3. `full`=1 held 5 cycles while a word is pending → `wr_req`/`wr_data`/`wr_mask` unchanged and `in_ready`=0 for those cycles. Drop `full` → single fire, `in_ready`=1 next cycle, no beat lost.
4. 8 continuous beats 0x01..0x08, `full`=0 → `in_ready` never drops; `wr_data` 0x04030201 then 0x08070605, exactly 2 writes.
5. Assert `rstn`=0 after 2 beats, then send 0x55,0x66,0x77,0x88 → single write 0x88776655, mask 0xF; the pre-reset beats never appear.
6. With `WR_PACK_MSB_FIRST_EN` defined, scenario 1 → `wr_data`=0x11223344, mask 0xF. Scenario 2 → `wr_data`=0xAABB0000, mask 0xC.
